// File: rtl/axis_symbol_sampler.sv
// ---------------------------------------------------------------------------
// axis_symbol_sampler : symbol-rate sampler / QPSK hard-decision packer for
// an IQ AXI-stream, with block-owned tlast framing.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_symbol_sampler #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 16,
  parameter int CNT_W = 32
) (
  input  logic               ce_clk,
  input  logic               ce_rst,
  input  logic               clear,
  input  logic [1:0]         mode,
  input  logic [LEN_W-1:0]   pkt_len,
  input  logic [2*WIDTH-1:0] i_tdata,
  input  logic               i_tstb,
  input  logic               i_tvalid,
  output logic               i_tready,
  output logic [2*WIDTH-1:0] o_tdata,
  output logic               o_tlast,
  output logic               o_tvalid,
  input  logic               o_tready,
  output logic [CNT_W-1:0]   sym_cnt
);

  localparam int PIDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(WIDTH - 1);
  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_PACK = 2'd2;

  logic               o_tvalid_q, o_tvalid_d;
  logic               o_tlast_q,  o_tlast_d;
  logic [2*WIDTH-1:0] o_tdata_q,  o_tdata_d;
  logic [2*WIDTH-1:0] pack_q,     pack_d;
  logic [PIDX_W-1:0]  pidx_q,     pidx_d;
  logic [LEN_W-1:0]   wcnt_q,     wcnt_d;
  logic [LEN_W-1:0]   len_q,      len_d;
  logic [1:0]         mode_q,     mode_d;
  logic [CNT_W-1:0]   sym_cnt_q,  sym_cnt_d;

  logic               w_boundary;
  logic [1:0]         w_mode;
  logic [LEN_W-1:0]   w_len;
  logic               w_accept;
  logic               w_sym_beat;
  logic               w_pack_beat;
  logic               w_produce;
  logic               w_last;
  logic [1:0]         w_sym;
  logic [2*WIDTH-1:0] w_pack_word;

  assign i_tready = ~ce_rst & (~o_tvalid_q | o_tready);
  assign o_tvalid = o_tvalid_q;
  assign o_tdata  = o_tdata_q;
  assign o_tlast  = o_tlast_q;
  assign sym_cnt  = sym_cnt_q;

  // At a packet boundary the live mode/length govern the beat in flight,
  // so the first beat of a new packet already follows the new settings.
  assign w_boundary  = (wcnt_q == '0) && (pidx_q == '0);
  assign w_mode      = w_boundary ? mode : mode_q;
  assign w_len       = w_boundary ? ((pkt_len == '0) ? LEN_W'(1) : pkt_len) : len_q;

  assign w_accept    = i_tvalid & i_tready;
  assign w_sym_beat  = w_accept & i_tstb & (w_mode != MODE_PASS);
  assign w_pack_beat = w_sym_beat & (w_mode == MODE_PACK);
  assign w_produce   = w_accept & ((w_mode == MODE_PASS) |
                       (i_tstb & ((w_mode != MODE_PACK) | (pidx_q == PIDX_LAST))));
  assign w_last      = (wcnt_q == (w_len - LEN_W'(1)));

  // Non-negative component decides 1; symbols shift in from the top so the
  // first symbol of a word ends up in the LSBs.
  assign w_sym       = {~i_tdata[2*WIDTH-1], ~i_tdata[WIDTH-1]};
  assign w_pack_word = {w_sym, pack_q[2*WIDTH-1:2]};

  always_comb begin
    o_tvalid_d = o_tvalid_q;
    o_tlast_d  = o_tlast_q;
    o_tdata_d  = o_tdata_q;
    pack_d     = pack_q;
    pidx_d     = pidx_q;
    wcnt_d     = wcnt_q;
    len_d      = w_len;
    mode_d     = w_mode;
    sym_cnt_d  = sym_cnt_q;

    if (o_tvalid_q && o_tready) begin
      o_tvalid_d = 1'b0;
    end

    if (clear) begin
      o_tvalid_d = 1'b0;
      o_tlast_d  = 1'b0;
      pack_d     = '0;
      pidx_d     = '0;
      wcnt_d     = '0;
      len_d      = len_q;
      mode_d     = mode_q;
    end else begin
      if (w_produce) begin
        o_tvalid_d = 1'b1;
        o_tdata_d  = (w_mode == MODE_PACK) ? w_pack_word : i_tdata;
        o_tlast_d  = w_last;
        wcnt_d     = w_last ? '0 : wcnt_q + LEN_W'(1);
      end
      if (w_pack_beat) begin
        pack_d = w_pack_word;
        pidx_d = (pidx_q == PIDX_LAST) ? '0 : pidx_q + PIDX_W'(1);
      end
      if (w_sym_beat) begin
        sym_cnt_d = sym_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      o_tvalid_q <= 1'b0;
      o_tlast_q  <= 1'b0;
      o_tdata_q  <= '0;
      pack_q     <= '0;
      pidx_q     <= '0;
      wcnt_q     <= '0;
      len_q      <= LEN_W'(1);
      mode_q     <= MODE_PASS;
      sym_cnt_q  <= '0;
    end else begin
      o_tvalid_q <= o_tvalid_d;
      o_tlast_q  <= o_tlast_d;
      o_tdata_q  <= o_tdata_d;
      pack_q     <= pack_d;
      pidx_q     <= pidx_d;
      wcnt_q     <= wcnt_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      sym_cnt_q  <= sym_cnt_d;
    end
  end

endmodule

`default_nettype wire
